wavepool_ctrl_rr: RTL and testbench
===================================

Name: wavepool_ctrl_rr

Overview:
Parametrised next-generation wavepool controller. It tracks a per-slot lifecycle state for every wavefront slot, steers fetch-buffer writes, vtail reservations and queue resets into per-slot strobes, and owns the feed decision internally. A round-robin arbiter with decode back-pressure replaces the externally supplied feed_wfid. The block sits between the fetch buffer/issue logic and the per-wavefront instruction queues, and drives the decode stage.

Parameters:
NUM_WF, 40, number of wavefront slots/queues
WFID_W, 6, width of every wfid/slotid field; must satisfy 2^WFID_W >= NUM_WF

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-high
buff_wfid  input  WFID_W  target slot of fetch-buffer write
buff_first  input  1  write is the first fetch of a (re)started stream
buff_ack  input  1  fetch-buffer write valid
q_wr  output  NUM_WF  one-hot queue write strobe
reserve_slotid  input  WFID_W  slot reserving a queue entry
reserve_valid  input  1  reservation valid
q_vtail_incr  output  NUM_WF  one-hot vtail increment
halt_wfid  input  WFID_W  slot being halted
wf_halt  input  1  halt valid
branch_wfid  input  WFID_W  slot of resolved branch
branch_en  input  1  branch resolution valid
branch_taken  input  1  branch taken
q_reset  output  NUM_WF  one-hot queue reset
q_empty  input  NUM_WF  per-queue empty flag, updated the cycle after q_rd
decode_ready  input  1  decode can accept an instruction this cycle
q_rd  output  NUM_WF  one-hot queue read strobe (at most one bit set)
valid_wf  output  NUM_WF  slot is in the ACTIVE state
decode_wfid  output  WFID_W  registered wfid of the issued instruction
decode_instr_valid  output  1  registered valid for decode_wfid

Behaviour:
- Per-slot state, 2 bits: IDLE=0, ACTIVE=1, FLUSH=2. Reset: all slots IDLE; decode_wfid=0; decode_instr_valid=0; RR pointer=NUM_WF-1. All combinational strobes are 0 while rst is high.
- Any wfid or slotid >= NUM_WF selects no slot. The event is ignored.
- q_reset[i] = (wf_halt & halt_wfid==i) | (branch_en & branch_taken & branch_wfid==i). It is combinational, in the same cycle as the request.
- State transitions, highest priority first:
  - halt hits slot -> IDLE.
  - Taken branch hits slot -> FLUSH.
  - buff_ack & buff_first hits slot -> ACTIVE.
  - Otherwise the state holds.
- q_wr[i] = buff_ack & buff_wfid==i & ~q_reset[i] & (buff_first | state==ACTIVE). Non-first writes to IDLE or FLUSH slots are dropped (stale fetch returns after a branch). A reset in the same cycle suppresses the write.
- q_vtail_incr[i] = reserve_valid & reserve_slotid==i. It is combinational and not gated by state.
- valid_wf[i] = (state[i]==ACTIVE). It is a registered view and does not anticipate the next state.
- Arbiter eligibility: eligible[i] = ACTIVE & ~q_empty[i] & ~q_reset[i] & ~(slot i granted in previous cycle). The last exclusion covers the one-cycle q_empty lag.
- Grant: when decode_ready=1, pick the first eligible slot searching from ptr+1 upward, wrapping at NUM_WF-1 -> 0. Assert q_rd for that slot in the same cycle and load ptr with its index. If decode_ready=0 or nothing is eligible, q_rd=0 and ptr holds.
- Decode outputs have 1-cycle latency. On the next edge, decode_wfid <= granted id and decode_instr_valid <= grant-happened. With no grant, decode_instr_valid <= 0 and decode_wfid holds.
- Kill rule: decode_instr_valid is combinationally masked low in any cycle where q_reset hits decode_wfid.
- Reset asserted mid-operation clears all state immediately. In-flight decode output is lost.

Decomposition:
- Shared package/defines: slot-state encodings (WFST_IDLE/ACTIVE/FLUSH) and default NUM_WF/WFID_W.
- One natural sub-module, rr_arbiter_param (NUM_WF, WFID_W): inputs are the request vector, enable and pointer; outputs are the one-hot grant, encoded id and grant-valid.
- The wfid decoders are generate loops and do not need their own module.

Test Plan:
- Reset, then buff_ack=1, buff_first=1, buff_wfid=5 -> q_wr=bit5 and valid_wf[5]=1 next cycle. Then buff_first=0, buff_wfid=7 -> q_wr=0 (slot 7 IDLE).
- Slots 0, 3 and 39 ACTIVE with queues non-empty and decode_ready=1 held -> grants in order 0, 3, 39, 0. decode_wfid follows one cycle later; a slot is never granted in two consecutive cycles.
- Slot 3 ACTIVE, branch_en=1, branch_taken=1, branch_wfid=3, with a simultaneous non-first buff_ack to 3 -> q_reset=bit3, q_wr=0, state FLUSH. A subsequent non-first write is dropped; buff_first -> ACTIVE.
- wf_halt and a taken branch to slot 2 in the same cycle -> q_reset=bit2 and slot 2 ends IDLE. halt_wfid=45 with NUM_WF=40 -> no effect.
- decode_ready=0 for 3 cycles with eligible slots -> q_rd=0 and ptr frozen. On release, the grant resumes after the previous winner.
- Grant slot 4, then wf_halt on slot 4 in the output cycle -> decode_instr_valid=0. Async rst pulse mid-stream -> outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/wavepool_ctrl_rr_pkg.sv
// Shared slot-state encodings and default sizing for the round-robin wavepool controller.
package wavepool_ctrl_rr_pkg;

    localparam int DEF_NUM_WF = 40;
    localparam int DEF_WFID_W = 6;

    typedef enum logic [1:0] {
        WFST_IDLE   = 2'd0,
        WFST_ACTIVE = 2'd1,
        WFST_FLUSH  = 2'd2
    } wfst_e;

endpackage

// File: rtl/wavepool_ctrl_rr_if.sv
// Fetch/issue/decode-side signal bundle of the wavepool controller.
interface wavepool_ctrl_rr_if
    import wavepool_ctrl_rr_pkg::*;
#(
    parameter int NUM_WF = DEF_NUM_WF,
    parameter int WFID_W = DEF_WFID_W
) ();

    logic [WFID_W-1:0] buff_wfid;
    logic              buff_first;
    logic              buff_ack;
    logic [NUM_WF-1:0] q_wr;
    logic [WFID_W-1:0] reserve_slotid;
    logic              reserve_valid;
    logic [NUM_WF-1:0] q_vtail_incr;
    logic [WFID_W-1:0] halt_wfid;
    logic              wf_halt;
    logic [WFID_W-1:0] branch_wfid;
    logic              branch_en;
    logic              branch_taken;
    logic [NUM_WF-1:0] q_reset;
    logic [NUM_WF-1:0] q_empty;
    logic              decode_ready;
    logic [NUM_WF-1:0] q_rd;
    logic [NUM_WF-1:0] valid_wf;
    logic [WFID_W-1:0] decode_wfid;
    logic              decode_instr_valid;

    modport slave (
        input  buff_wfid, buff_first, buff_ack,
        input  reserve_slotid, reserve_valid,
        input  halt_wfid, wf_halt,
        input  branch_wfid, branch_en, branch_taken,
        input  q_empty, decode_ready,
        output q_wr, q_vtail_incr, q_reset, q_rd, valid_wf,
        output decode_wfid, decode_instr_valid
    );

    modport master (
        output buff_wfid, buff_first, buff_ack,
        output reserve_slotid, reserve_valid,
        output halt_wfid, wf_halt,
        output branch_wfid, branch_en, branch_taken,
        output q_empty, decode_ready,
        input  q_wr, q_vtail_incr, q_reset, q_rd, valid_wf,
        input  decode_wfid, decode_instr_valid
    );

endinterface

// File: rtl/wavepool_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester strictly after ptr, wrapping at NUM_WF-1.
module rr_arbiter_param
    import wavepool_ctrl_rr_pkg::*;
#(
    parameter int NUM_WF = DEF_NUM_WF,
    parameter int WFID_W = DEF_WFID_W
) (
    input  logic [NUM_WF-1:0] req,
    input  logic              en,
    input  logic [WFID_W-1:0] ptr,
    output logic [NUM_WF-1:0] grant,
    output logic [WFID_W-1:0] gnt_id,
    output logic              gnt_vld
);

    int                sum;
    logic [WFID_W-1:0] idx;
    logic              found;

    // ptr is always a valid slot index, so a single subtraction wraps the search.
    always_comb begin
        grant   = '0;
        gnt_id  = '0;
        found   = 1'b0;
        sum     = 0;
        idx     = '0;
        if (en) begin
            for (int k = 1; k <= NUM_WF; k++) begin
                sum = int'(ptr) + k;
                if (sum >= NUM_WF) sum = sum - NUM_WF;
                idx = WFID_W'(sum);
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    gnt_id     = idx;
                end
            end
        end
        gnt_vld = found;
    end

endmodule

// File: rtl/wavepool_ctrl_rr.sv
// Wavepool controller: per-slot lifecycle, queue strobe steering and round-robin feed to decode.
module wavepool_ctrl_rr
    import wavepool_ctrl_rr_pkg::*;
#(
    parameter int NUM_WF = DEF_NUM_WF,
    parameter int WFID_W = DEF_WFID_W
) (
    input  logic               clk,
    input  logic               rst,
    wavepool_ctrl_rr_if.slave  bus
);

    logic [NUM_WF-1:0] first_hit, buff_hit, halt_hit, br_hit, rsv_hit, reset_hit;
    logic [NUM_WF-1:0] active, wr_ok, eligible;
    logic [NUM_WF-1:0] gnt_p0, last_gnt_p1;
    logic [WFID_W-1:0] gnt_id_p0, dec_wfid_p1, ptr;
    logic              gnt_vld_p0, dec_vld_p1, kill;

    // Out-of-range ids match no ID constant, so they fall through as no-ops.
    for (genvar i = 0; i < NUM_WF; i++) begin : g_slot
        localparam logic [WFID_W-1:0] ID = WFID_W'(i);
        wfst_e st;

        assign buff_hit[i]  = bus.buff_ack && (bus.buff_wfid == ID);
        assign first_hit[i] = buff_hit[i] && bus.buff_first;
        assign halt_hit[i]  = bus.wf_halt && (bus.halt_wfid == ID);
        assign br_hit[i]    = bus.branch_en && bus.branch_taken && (bus.branch_wfid == ID);
        assign rsv_hit[i]   = bus.reserve_valid && (bus.reserve_slotid == ID);
        assign reset_hit[i] = halt_hit[i] || br_hit[i];
        assign active[i]    = (st == WFST_ACTIVE);
        assign wr_ok[i]     = buff_hit[i] && !reset_hit[i] && (bus.buff_first || active[i]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst)               st <= WFST_IDLE;
            else if (halt_hit[i])  st <= WFST_IDLE;
            else if (br_hit[i])    st <= WFST_FLUSH;
            else if (first_hit[i]) st <= WFST_ACTIVE;
        end
    end

    // The previous winner is excluded because its q_empty has not caught up yet.
    assign eligible = active & ~bus.q_empty & ~reset_hit & ~last_gnt_p1;

    rr_arbiter_param #(
        .NUM_WF (NUM_WF),
        .WFID_W (WFID_W)
    ) u_arb (
        .req     (eligible),
        .en      (bus.decode_ready),
        .ptr     (ptr),
        .grant   (gnt_p0),
        .gnt_id  (gnt_id_p0),
        .gnt_vld (gnt_vld_p0)
    );

    // p0 -> p1: grant registered toward decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= WFID_W'(NUM_WF - 1);
            last_gnt_p1 <= '0;
            dec_vld_p1  <= 1'b0;
            dec_wfid_p1 <= '0;
        end else begin
            last_gnt_p1 <= gnt_p0;
            dec_vld_p1  <= gnt_vld_p0;
            if (gnt_vld_p0) begin
                ptr         <= gnt_id_p0;
                dec_wfid_p1 <= gnt_id_p0;
            end
        end
    end

    assign kill = |(reset_hit & (NUM_WF'(1) << dec_wfid_p1));

    assign bus.q_reset            = rst ? '0 : reset_hit;
    assign bus.q_wr               = rst ? '0 : wr_ok;
    assign bus.q_vtail_incr       = rst ? '0 : rsv_hit;
    assign bus.q_rd               = rst ? '0 : gnt_p0;
    assign bus.valid_wf           = active;
    assign bus.decode_wfid        = dec_wfid_p1;
    assign bus.decode_instr_valid = dec_vld_p1 && !kill;

endmodule

// File: tb/tb_wavepool_ctrl_rr.sv
// Scoreboarded bench for wavepool_ctrl_rr: directed scenarios plus a randomized soak.
module tb_wavepool_ctrl_rr;
    import wavepool_ctrl_rr_pkg::*;

    localparam int NUM_WF = 40;
    localparam int WFID_W = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wavepool_ctrl_rr_if #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) bus ();

    wavepool_ctrl_rr #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    int                m_st [NUM_WF];
    int                m_ptr;
    int                m_dec_id;
    logic [NUM_WF-1:0] m_last;
    logic [WFID_W:0]   sb [$];

    logic [NUM_WF-1:0] obs_wr, obs_rst, obs_rd;
    logic              obs_dv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2id(input logic [NUM_WF-1:0] v);
        int r = -1;
        for (int i = NUM_WF - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [NUM_WF-1:0] bit_of(input int i);
        logic [NUM_WF-1:0] v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic idle();
        bus.buff_wfid      = '0;
        bus.buff_first     = 1'b0;
        bus.buff_ack       = 1'b0;
        bus.reserve_slotid = '0;
        bus.reserve_valid  = 1'b0;
        bus.halt_wfid      = '0;
        bus.wf_halt        = 1'b0;
        bus.branch_wfid    = '0;
        bus.branch_en      = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.q_empty        = '1;
        bus.decode_ready   = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_WF; i++) m_st[i] = 0;
        m_ptr    = NUM_WF - 1;
        m_dec_id = 0;
        m_last   = '0;
        sb.delete();
        sb.push_back('0);
    endtask

    // One clock: compare at negedge against the model, push next decode, advance model.
    task automatic step();
        logic [NUM_WF-1:0] e_rst, e_wr, e_vt, e_rd, e_val, elig;
        logic [WFID_W:0]   ent;
        int                eid, gid, idx;
        bit                found;
        @(negedge clk);
        e_rst = '0; e_wr = '0; e_vt = '0; e_rd = '0; e_val = '0; elig = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            e_rst[i] = (bus.wf_halt && bus.halt_wfid == i) ||
                       (bus.branch_en && bus.branch_taken && bus.branch_wfid == i);
            e_wr[i]  = bus.buff_ack && bus.buff_wfid == i && !e_rst[i] &&
                       (bus.buff_first || m_st[i] == 1);
            e_vt[i]  = bus.reserve_valid && bus.reserve_slotid == i;
            e_val[i] = (m_st[i] == 1);
            elig[i]  = (m_st[i] == 1) && !bus.q_empty[i] && !e_rst[i] && !m_last[i];
        end
        found = 0;
        gid   = 0;
        if (bus.decode_ready) begin
            for (int k = 1; k <= NUM_WF; k++) begin
                idx = (m_ptr + k) % NUM_WF;
                if (!found && elig[idx]) begin
                    found = 1;
                    gid   = idx;
                end
            end
        end
        if (found) e_rd[gid] = 1'b1;

        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_underflow: got empty queue want one entry");
        end else begin
            ent = sb.pop_front();
            eid = int'(ent[WFID_W-1:0]);
            chk("decode_wfid", bus.decode_wfid, ent[WFID_W-1:0]);
            chk("decode_vld", bus.decode_instr_valid, ent[WFID_W] & ~e_rst[eid]);
        end
        chk("q_reset", bus.q_reset, e_rst);
        chk("q_wr", bus.q_wr, e_wr);
        chk("q_vtail", bus.q_vtail_incr, e_vt);
        chk("q_rd", bus.q_rd, e_rd);
        chk("valid_wf", bus.valid_wf, e_val);
        obs_wr  = bus.q_wr;
        obs_rst = bus.q_reset;
        obs_rd  = bus.q_rd;
        obs_dv  = bus.decode_instr_valid;

        if (found) begin
            m_ptr    = gid;
            m_dec_id = gid;
        end
        m_last = e_rd;
        sb.push_back({found, WFID_W'(m_dec_id)});
        for (int i = 0; i < NUM_WF; i++) begin
            if (bus.wf_halt && bus.halt_wfid == i) m_st[i] = 0;
            else if (bus.branch_en && bus.branch_taken && bus.branch_wfid == i) m_st[i] = 2;
            else if (bus.buff_ack && bus.buff_first && bus.buff_wfid == i) m_st[i] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        bus.buff_ack = 1'b1; bus.buff_first = 1'b1; bus.buff_wfid = 6'd1;
        bus.reserve_valid = 1'b1; bus.reserve_slotid = 6'd1;
        bus.wf_halt = 1'b1; bus.halt_wfid = 6'd1;
        bus.decode_ready = 1'b1; bus.q_empty = '0;
        @(posedge clk);
        #1;
        chk("rst_q_wr", bus.q_wr, 0);
        chk("rst_q_vtail", bus.q_vtail_incr, 0);
        chk("rst_q_reset", bus.q_reset, 0);
        chk("rst_q_rd", bus.q_rd, 0);
        chk("rst_valid_wf", bus.valid_wf, 0);
        chk("rst_dec_wfid", bus.decode_wfid, 0);
        chk("rst_dec_vld", bus.decode_instr_valid, 0);
        idle();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_first(input int id);
        idle();
        bus.buff_ack = 1'b1; bus.buff_first = 1'b1; bus.buff_wfid = WFID_W'(id);
        step();
        idle();
    endtask

    function automatic logic [WFID_W-1:0] rid();
        if ($urandom_range(0, 9) == 0) return WFID_W'($urandom_range(40, 63));
        return WFID_W'($urandom_range(0, 9));
    endfunction

    initial begin
        int                g [4];
        logic [NUM_WF-1:0] ne;
        logic [9:0]        rnd;

        rst = 1'b1;
        idle();
        #12;
        do_reset();

        // first write activates slot 5; non-first write to idle slot 7 is dropped
        bus.buff_ack = 1'b1; bus.buff_first = 1'b1; bus.buff_wfid = 6'd5;
        step();
        chk("s1_wr5", obs_wr, bit_of(5));
        chk("s1_valid5", bus.valid_wf, bit_of(5));
        bus.buff_first = 1'b0; bus.buff_wfid = 6'd7;
        bus.reserve_valid = 1'b1; bus.reserve_slotid = 6'd9;
        step();
        chk("s1_wr7", obs_wr, 0);
        idle();

        // round-robin over slots 0, 3, 39
        write_first(0);
        write_first(3);
        write_first(39);
        ne = bit_of(0) | bit_of(3) | bit_of(39);
        bus.q_empty = ~ne;
        bus.decode_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            g[j] = oh2id(obs_rd);
        end
        chk("s2_g0", g[0], 0);
        chk("s2_g1", g[1], 3);
        chk("s2_g2", g[2], 39);
        chk("s2_g3", g[3], 0);

        // back-pressure freezes the pointer
        bus.decode_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("s3_frozen", obs_rd, 0);
        end
        bus.decode_ready = 1'b1;
        step();
        chk("s3_resume", oh2id(obs_rd), 3);
        idle();

        // taken branch on slot 3 with a simultaneous stale write
        bus.branch_en = 1'b1; bus.branch_taken = 1'b1; bus.branch_wfid = 6'd3;
        bus.buff_ack = 1'b1; bus.buff_first = 1'b0; bus.buff_wfid = 6'd3;
        step();
        chk("s4_reset3", obs_rst, bit_of(3));
        chk("s4_wr_sup", obs_wr, 0);
        chk("s4_flush", bus.valid_wf[3], 0);
        idle();
        bus.buff_ack = 1'b1; bus.buff_wfid = 6'd3;
        step();
        chk("s4_stale", obs_wr, 0);
        bus.buff_first = 1'b1;
        step();
        chk("s4_restart", obs_wr, bit_of(3));
        chk("s4_active", bus.valid_wf[3], 1);
        idle();

        // halt and branch on slot 2 together, then an out-of-range halt
        write_first(2);
        bus.wf_halt = 1'b1; bus.halt_wfid = 6'd2;
        bus.branch_en = 1'b1; bus.branch_taken = 1'b1; bus.branch_wfid = 6'd2;
        step();
        chk("s5_reset2", obs_rst, bit_of(2));
        chk("s5_idle2", bus.valid_wf[2], 0);
        idle();
        bus.wf_halt = 1'b1; bus.halt_wfid = 6'd45;
        step();
        chk("s5_oor_reset", obs_rst, 0);
        chk("s5_oor_valid", bus.valid_wf, bit_of(0) | bit_of(3) | bit_of(5) | bit_of(39));
        idle();

        // kill of an in-flight decode, then asynchronous reset
        write_first(4);
        bus.q_empty = ~bit_of(4);
        bus.decode_ready = 1'b1;
        step();
        chk("s6_grant4", oh2id(obs_rd), 4);
        idle();
        bus.wf_halt = 1'b1; bus.halt_wfid = 6'd4;
        step();
        chk("s6_kill", obs_dv, 0);
        idle();
        bus.q_empty = ~bit_of(3);
        bus.decode_ready = 1'b1;
        step();
        chk("s6_pre_rst", bus.decode_instr_valid, 1);
        rst = 1'b1;
        #1;
        chk("s6_async_vld", bus.decode_instr_valid, 0);
        chk("s6_async_wfid", bus.decode_wfid, 0);
        chk("s6_async_qrd", bus.q_rd, 0);
        chk("s6_async_valid", bus.valid_wf, 0);
        do_reset();

        // randomized soak against the model
        for (int c = 0; c < 400; c++) begin
            bus.buff_ack       = 1'($urandom_range(0, 1));
            bus.buff_first     = ($urandom_range(0, 3) == 0);
            bus.buff_wfid      = rid();
            bus.reserve_valid  = 1'($urandom_range(0, 1));
            bus.reserve_slotid = rid();
            bus.wf_halt        = ($urandom_range(0, 7) == 0);
            bus.halt_wfid      = rid();
            bus.branch_en      = ($urandom_range(0, 4) == 0);
            bus.branch_taken   = 1'($urandom_range(0, 1));
            bus.branch_wfid    = rid();
            rnd                = 10'($urandom);
            bus.q_empty        = {{(NUM_WF-10){1'b1}}, rnd};
            bus.decode_ready   = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
